// File: rtl/cnn_frame_streamer_if.sv
// Frame streamer bus: control, frame-memory read port and pixel stream.
// master = streamer side, slave = memory / consumer side.
interface cnn_frame_streamer_if #(
    parameter int DATA_W = 9,
    parameter int ADDR_W = 10,
    parameter int RC_W   = 5
);
    logic                     start;
    logic                     hold;
    logic                     rom_en;
    logic [ADDR_W-1:0]        rom_addr;
    logic signed [DATA_W-1:0] rom_data;
    logic signed [DATA_W-1:0] pix_out;
    logic                     pix_valid;
    logic [RC_W-1:0]          pix_row;
    logic [RC_W-1:0]          pix_col;
    logic                     win_valid;
    logic                     frame_last;
    logic                     busy;
    logic                     done;

    modport master (
        input  start, hold, rom_data,
        output rom_en, rom_addr, pix_out, pix_valid, pix_row, pix_col,
        output win_valid, frame_last, busy, done
    );

    modport slave (
        output start, hold, rom_data,
        input  rom_en, rom_addr, pix_out, pix_valid, pix_row, pix_col,
        input  win_valid, frame_last, busy, done
    );
endinterface

// File: rtl/cnn_frame_streamer.sv
// Reads one raster-order frame from a sync-read memory and streams it
// as registered pixels with row/col tags and a KxK window-valid flag.
module cnn_frame_streamer #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int DATA_W = 9,
    parameter int ADDR_W = 10,
    parameter int K      = 5,
    parameter int RC_W   = 5
) (
    input logic clk,
    input logic rstn,
    cnn_frame_streamer_if.master bus
);
    localparam int NPIX = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [RC_W-1:0]   ROW_MAX   = RC_W'(IMG_H - 1);
    localparam logic [RC_W-1:0]   COL_MAX   = RC_W'(IMG_W - 1);
    localparam logic [RC_W-1:0]   WIN_MIN   = RC_W'(K - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t            state;
    state_t            state_nx;
    logic              en_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic              issue_d;
    logic [RC_W-1:0]   row_cnt;
    logic [RC_W-1:0]   col_cnt;
    logic              go;
    logic              last_issue;
    logic              last_pix;

    assign go         = (state == IDLE) && bus.start;
    assign last_issue = (state == READ) && bus.rom_en
                        && (bus.rom_addr == LAST_ADDR);
    assign last_pix   = bus.pix_valid && bus.frame_last;
    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == DONE);

    // Next state and next read request; rom_addr keeps the last issued
    // address across hold bubbles so the next issue is simply +1.
    always_comb begin
        state_nx = state;
        en_nx    = 1'b0;
        addr_nx  = bus.rom_addr;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = READ;
                    en_nx    = 1'b1;
                    addr_nx  = '0;
                end
            end
            READ: begin
                if (last_issue) begin
                    state_nx = DRAIN;
                end else if (!bus.hold) begin
                    en_nx   = 1'b1;
                    addr_nx = bus.rom_addr + 1'b1;
                end
            end
            DRAIN: begin
                if (last_pix) state_nx = DONE;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    // Registered memory read port.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.rom_en   <= 1'b0;
            bus.rom_addr <= '0;
        end else begin
            bus.rom_en   <= en_nx;
            bus.rom_addr <= addr_nx;
        end
    end

    // Pixel pipeline: issue flag delayed to match memory latency, then
    // data and tags registered together; row/col counters name the
    // next pixel to come out.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            issue_d        <= 1'b0;
            row_cnt        <= '0;
            col_cnt        <= '0;
            bus.pix_out    <= '0;
            bus.pix_valid  <= 1'b0;
            bus.pix_row    <= '0;
            bus.pix_col    <= '0;
            bus.win_valid  <= 1'b0;
            bus.frame_last <= 1'b0;
        end else begin
            issue_d <= bus.rom_en;
            if (go) begin
                row_cnt        <= '0;
                col_cnt        <= '0;
                bus.pix_row    <= '0;
                bus.pix_col    <= '0;
                bus.pix_valid  <= 1'b0;
                bus.win_valid  <= 1'b0;
                bus.frame_last <= 1'b0;
            end else if (issue_d) begin
                bus.pix_out    <= bus.rom_data;
                bus.pix_valid  <= 1'b1;
                bus.pix_row    <= row_cnt;
                bus.pix_col    <= col_cnt;
                bus.win_valid  <= (row_cnt >= WIN_MIN)
                                  && (col_cnt >= WIN_MIN);
                bus.frame_last <= (row_cnt == ROW_MAX)
                                  && (col_cnt == COL_MAX);
                if (col_cnt == COL_MAX) begin
                    col_cnt <= '0;
                    row_cnt <= (row_cnt == ROW_MAX) ? '0
                                                    : row_cnt + 1'b1;
                end else begin
                    col_cnt <= col_cnt + 1'b1;
                end
            end else begin
                bus.pix_valid  <= 1'b0;
                bus.win_valid  <= 1'b0;
                bus.frame_last <= 1'b0;
            end
        end
    end
endmodule

// File: doc/cnn_frame_streamer.md
Name: cnn_frame_streamer

Overview:
- Producer end of the CNN window pixel stream.
- On start, reads one IMG_H x IMG_W frame of signed 9-bit pixels, in raster order, from a synchronous-read ROM/RAM.
- Emits the pixels as a registered stream with valid, row/col tags and a window-valid flag for the downstream line buffer / 5x5 window generator.
- Sits between the frame memory and the CNN_windows shift-in port.

Parameters:
- IMG_W, 28, pixels per row.
- IMG_H, 28, rows per frame.
- DATA_W, 9, pixel width (signed).
- ADDR_W, 10, memory address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- K, 5, window size used for win_valid.
- RC_W, 5, width of the row/col tags; must hold max(IMG_W, IMG_H)-1.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  frame request; sampled only in IDLE.
- hold  in  1  pause; suppresses the next memory read issue.
- rom_en  out  1  read strobe, registered.
- rom_addr  out  ADDR_W  read address, registered.
- rom_data  in  DATA_W  memory read data; valid 1 cycle after rom_en.
- pix_out  out  DATA_W  pixel, registered.
- pix_valid  out  1  pix_out valid.
- pix_row  out  RC_W  row index of pix_out.
- pix_col  out  RC_W  column index of pix_out.
- win_valid  out  1  pix_valid AND pix_row>=K-1 AND pix_col>=K-1.
- frame_last  out  1  with the final pixel (row IMG_H-1, col IMG_W-1).
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse after the final pixel.

Behaviour:
- Reset (async, rstn=0): state IDLE. Every output is 0, including rom_addr, pix_out, pix_row and pix_col. The internal issue pipeline is cleared.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - start=1 -> READ.
  - On that edge: rom_en<=1, rom_addr<=0.
- READ:
  - Each cycle with hold=0: rom_en<=1, rom_addr<=rom_addr+1.
  - hold=1: rom_en<=0 and rom_addr holds.
  - When the issued address is IMG_W*IMG_H-1 -> DRAIN, with rom_en<=0.
- DRAIN: wait until the final pixel is registered (pix_valid with frame_last) -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE.
- start is ignored outside IDLE. A start held high starts a new frame on the first IDLE cycle, so back-to-back frames have one idle cycle between them.
- Data pipeline:
  - An issue flag is delayed 1 cycle to match ROM latency.
  - When the delayed flag is 1, pix_out<=rom_data and pix_valid<=1; otherwise pix_valid<=0 and pix_out holds.
  - Latency: rom_en in cycle t gives pix_valid in cycle t+2.
  - start sampled in cycle 0 gives the first pix_valid in cycle 3.
  - With no hold, pixels are contiguous in cycles 3 to N+2 (N=IMG_W*IMG_H), and done=1 in cycle N+3.
- Row/col tags:
  - Update only with pix_valid. col increments and wraps IMG_W-1 -> 0; on wrap, row increments.
  - Both tags reset to 0 at each new frame start.
  - Tags hold across hold bubbles.
- win_valid is combinationally derived from registered outputs, or registered in the same cycle; it is never high without pix_valid. Downstream applies its own column-register alignment.
- hold:
  - hold=1 in cycle t gives no issue in cycle t+1 and a pix_valid bubble in cycle t+3.
  - Pixel order is never altered.
  - hold in IDLE, DRAIN or DONE has no effect.
- rstn asserted mid-frame: immediate return to IDLE with all outputs 0. No done pulse. The next start restarts from address 0, row 0, col 0.
- Arithmetic: unsigned address and counters; pixel data is passed through unmodified (signed interpretation is downstream).

Test Plan:
1. Reset: hold rstn=0 for 2 cycles with start=1 -> every output is 0, busy=0, and no rom_en.
2. Single frame: memory[i] = i mod 512, start pulse in cycle 0, hold=0 ->
   - pix_valid high in cycles 3..786 (784 pixels), pix_out = i mod 512 in order.
   - frame_last only in cycle 786 (row 27, col 27); done only in cycle 787; busy high in cycles 1..787.
3. Window flag: same frame ->
   - win_valid asserted exactly 576 times.
   - First at pixel index 116 (row 4, col 4), last at index 783.
   - Deasserted at index 140 (row 5, col 0).
4. Row/col wrap: pixel index 27 -> row 0, col 27; index 28 -> row 1, col 0; index 55 -> row 1, col 27.
5. Backpressure: hold=1 for 10 consecutive cycles starting at cycle 100 -> exactly 10 pix_valid bubbles starting at cycle 103, data sequence intact, done delayed to cycle 797.
6. Control:
   - start pulsed mid-frame -> ignored.
   - rstn pulsed low at cycle 400 -> outputs 0 immediately and no done.
   - Subsequent start -> first pixel is memory[0] with row 0, col 0.
   - start held high -> second frame's rom_en rises 2 cycles after done.
